// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light slice: channel map, channel count and
// clock rate. The sensor conditioner and the traffic FSM both import this.
package traffic_pkg;

  localparam int unsigned NUM_CH           = 5;

  localparam int unsigned CH_LEFT_MAIN     = 0;
  localparam int unsigned CH_LEFT_CROSS    = 1;
  localparam int unsigned CH_TRAFFIC_CROSS = 2;
  localparam int unsigned CH_WALK_MAIN     = 3;
  localparam int unsigned CH_WALK_CROSS    = 4;

  localparam int unsigned CLK_HZ           = 50_000_000;

  // Converts a duration in milliseconds to clk cycles at CLK_HZ.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// Single-bit sensor conditioner: 2-flop synchroniser, debounce counter,
// rising-edge pulse and sticky request. With SENSOR_STUCK_DETECT_EN defined
// it also flags a level that stays high too long and masks its request.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
`ifdef SENSOR_STUCK_DETECT_EN
  , parameter int unsigned STUCK_CYCLES  = 1_500_000_000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic clr,
  output logic level,
  output logic req,
  output logic rise,
  output logic fault
);

  import traffic_pkg::*;

  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             rise_q;
  logic             req_q;
  logic             fault_q;
  logic             qualify;
  logic             set_req;

  // Synchronised sample has differed from the level for the full window.
  always_comb begin
    qualify = (sync2 != level_q) && (cnt == CNT_LAST);
    set_req = qualify && sync2;
  end

  // Two-flop synchroniser for the asynchronous board input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Debounce: any agreement with the current level restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt     <= '0;
    end else if (sync2 == level_q) begin
      cnt     <= '0;
    end else if (cnt == CNT_LAST) begin
      level_q <= sync2;
      cnt     <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  // Rise pulse on the same edge the level goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= set_req;
    end
  end

  // Sticky request: a new press beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
    end else if (set_req) begin
      req_q <= 1'b1;
    end else if (fault_q || clr) begin
      req_q <= 1'b0;
    end
  end

`ifdef SENSOR_STUCK_DETECT_EN
  localparam int unsigned      STK_W    = $clog2(STUCK_CYCLES);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

  logic [STK_W-1:0] stk;

  // Stuck detector: counts high time, saturates and flags at the limit.
  always_ff @(posedge clk) begin
    if (rst || !level_q) begin
      stk     <= '0;
      fault_q <= 1'b0;
    end else if (stk == STK_LAST) begin
      fault_q <= 1'b1;
    end else begin
      stk     <= stk + 1'b1;
    end
  end

  // The stored request is cleared one edge after a fault appears, so it is
  // masked here to hide it on the edge the fault itself is raised.
  always_comb begin
    req   = req_q && !fault_q;
    fault = fault_q;
  end
`else
  assign fault_q = 1'b0;

  // No stuck detection: the request is passed straight through.
  always_comb begin
    req   = req_q;
    fault = 1'b0;
  end
`endif

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor conditioner feeding the traffic FSM's sensors[4:0] input: one
// debounce_channel per raw board input. Optional stuck-sensor detection is
// enabled by defining SENSOR_STUCK_DETECT_EN; otherwise fault is tied to 0.
module sensor_conditioner #(
  parameter int unsigned NUM_CH          = traffic_pkg::NUM_CH,
  parameter int unsigned DEBOUNCE_CYCLES = traffic_pkg::ms_to_cycles(10),
  parameter int unsigned STUCK_CYCLES    = traffic_pkg::ms_to_cycles(30_000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fault
);

  import traffic_pkg::*;

  // Channels are fully independent; one instance per input bit.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SENSOR_STUCK_DETECT_EN
      , .STUCK_CYCLES  (STUCK_CYCLES)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_in[g]),
      .clr    (clr[g]),
      .level  (level[g]),
      .req    (req[g]),
      .rise   (rise[g]),
      .fault  (fault[g])
    );
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
// Honours SENSOR_STUCK_DETECT_EN in the same way as the design.
module tb_sensor_conditioner;

  import traffic_pkg::*;

  localparam int NCH = 5;
  localparam int DB  = 4;
  localparam int STK = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] raw_in = '0;
  logic [NCH-1:0] clr = '0;
  logic [NCH-1:0] level;
  logic [NCH-1:0] req;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fault;

  int checks = 0;
  int errors = 0;

  sensor_conditioner #(
    .NUM_CH          (NCH),
    .DEBOUNCE_CYCLES (DB),
    .STUCK_CYCLES    (STK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .clr    (clr),
    .level  (level),
    .req    (req),
    .rise   (rise),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press is accepted once the synchronised input (the raw
  // value two edges ago) has held one value for DB consecutive edges and that
  // value differs from the accepted level.
  bit m_p1 [NCH];
  bit m_p2 [NCH];
  bit m_last [NCH];
  int m_run [NCH];
  bit m_level [NCH];
  bit m_rise [NCH];
  bit m_req [NCH];
  bit m_fault [NCH];
  int m_hi [NCH];
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    bit s;
    bit nl;
    bit nf;
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_p1[i] = 0; m_p2[i] = 0; m_last[i] = 0; m_run[i] = 0;
        m_level[i] = 0; m_rise[i] = 0; m_req[i] = 0; m_fault[i] = 0; m_hi[i] = 0;
      end else begin
        s = m_p2[i];
        if (s == m_last[i]) m_run[i] = (m_run[i] < DB) ? m_run[i] + 1 : DB;
        else m_run[i] = 1;
        m_last[i] = s;
        nl = (m_run[i] >= DB && s != m_level[i]) ? s : m_level[i];
        m_rise[i] = nl && !m_level[i];
`ifdef SENSOR_STUCK_DETECT_EN
        if (!m_level[i]) m_hi[i] = 0;
        else m_hi[i] = (m_hi[i] < STK) ? m_hi[i] + 1 : STK;
        nf = (m_hi[i] >= STK);
`else
        nf = 0;
`endif
        if (m_rise[i]) m_req[i] = 1;
        else if (clr[i] || m_fault[i]) m_req[i] = 0;
        m_fault[i] = nf;
        m_level[i] = nl;
        m_p2[i] = m_p1[i];
        m_p1[i] = raw_in[i];
      end
    end
    if (rst) chk_en = 1'b1;
  end

  // Every cycle, compare all outputs against the model away from the edge.
  always @(negedge clk) begin
    logic [NCH-1:0] el, er, eq, ef;
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        el[i] = m_level[i];
        er[i] = m_rise[i];
        eq[i] = m_req[i] && !m_fault[i];
        ef[i] = m_fault[i];
      end
      check("model_level", 32'(level), 32'(el));
      check("model_rise", 32'(rise), 32'(er));
      check("model_req", 32'(req), 32'(eq));
      check("model_fault", 32'(fault), 32'(ef));
    end
  end

  initial begin
    // Reset with all inputs high.
    rst = 1'b1;
    raw_in = 5'b11111;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(level), 32'h0);
    check("rst_req", 32'(req), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_prelevel", 32'(level), 32'h0);
    @(negedge clk);
    check("rst_level_up", 32'(level), 32'h1f);
    check("rst_rise_up", 32'(rise), 32'h1f);
    check("rst_req_up", 32'(req), 32'h1f);
    @(negedge clk);
    check("rst_rise_once", 32'(rise), 32'h0);
    raw_in = '0;
    repeat (8) @(negedge clk);
    clr = 5'b11111;
    @(negedge clk);
    clr = '0;
    check("clr_all", 32'(req), 32'h0);

    // Glitch of 3 cycles on ch2.
    raw_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    raw_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_level", 32'(level[2]), 32'h0);
    check("glitch_req", 32'(req[2]), 32'h0);

    // Clean press on ch0, held 10 cycles.
    raw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("ch0_pre", 32'(level[0]), 32'h0);
    @(negedge clk);
    check("ch0_level", 32'(level[0]), 32'h1);
    check("ch0_rise", 32'(rise[0]), 32'h1);
    @(negedge clk);
    check("ch0_rise_end", 32'(rise[0]), 32'h0);
    repeat (3) @(negedge clk);
    raw_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("ch0_released", 32'(level[0]), 32'h0);
    check("ch0_req_kept", 32'(req[0]), 32'h1);

    // Clear/set collision on ch1.
    raw_in[1] = 1'b1;
    repeat (8) @(negedge clk);
    raw_in[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("ch1_req_held", 32'(req[1]), 32'h1);
    raw_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    check("collide_rise", 32'(rise[1]), 32'h1);
    check("collide_req", 32'(req[1]), 32'h1);
    repeat (3) @(negedge clk);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    check("lone_clr", 32'(req[1]), 32'h0);
    raw_in[1] = 1'b0;

    // Independence of ch3 and ch4.
    raw_in[3] = 1'b1;
    repeat (2) @(negedge clk);
    raw_in[4] = 1'b1;
    repeat (3) @(negedge clk);
    check("ch3_pre", 32'(req[3]), 32'h0);
    @(negedge clk);
    check("ch3_req", 32'(req[3]), 32'h1);
    check("ch4_pre", 32'(req[4]), 32'h0);
    repeat (2) @(negedge clk);
    check("ch4_req", 32'(req[4]), 32'h1);
    clr[3] = 1'b1;
    @(negedge clk);
    clr[3] = 1'b0;
    check("ch3_clr", 32'(req[3]), 32'h0);
    check("ch4_kept", 32'(req[4]), 32'h1);
    raw_in[3] = 1'b0;
    raw_in[4] = 1'b0;
    repeat (8) @(negedge clk);
    clr = 5'b11111;
    @(negedge clk);
    clr = '0;

    // Long hold on ch2.
    raw_in[2] = 1'b1;
    repeat (26) @(negedge clk);
`ifdef SENSOR_STUCK_DETECT_EN
    check("stuck_fault", 32'(fault[2]), 32'h1);
    check("stuck_req_masked", 32'(req[2]), 32'h0);
    raw_in[2] = 1'b0;
    repeat (6) @(negedge clk);
    check("stuck_level_low", 32'(level[2]), 32'h0);
    check("stuck_fault_lag", 32'(fault[2]), 32'h1);
    @(negedge clk);
    check("stuck_fault_clr", 32'(fault[2]), 32'h0);
    check("stuck_req_gone", 32'(req[2]), 32'h0);
`else
    check("nostuck_fault", 32'(fault), 32'h0);
    check("nostuck_req", 32'(req[2]), 32'h1);
    raw_in[2] = 1'b0;
    repeat (7) @(negedge clk);
`endif

    // Randomised traffic: fast toggling, then slow toggling with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NCH; i++) begin
        if (n < 2000) begin
          if ($urandom_range(0, 7) == 0) raw_in[i] = ~raw_in[i];
        end else begin
          if ($urandom_range(0, 59) == 0) raw_in[i] = ~raw_in[i];
        end
        clr[i] = ($urandom_range(0, 9) == 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    clr = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
